serial_adder_controller: RTL and testbench
==========================================

# serial_adder_controller

Multi-cycle controller that sequences one shared 4-bit ripple adder to perform WIDTH-bit signed/unsigned add and subtract, one nibble per clock, least-significant nibble first. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area in the arithmetic-operations datapath: one nibble adder serves any operand width.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4. NIB = WIDTH/4 is derived.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands a, b, sub are valid
- in_ready  out  1  controller can accept an operation
- a  in  WIDTH  first operand
- b  in  WIDTH  second operand
- sub  in  1  0: a+b; 1: a−b
- sat  in  1  saturate on signed overflow (present only with SERIAL_ADDER_SAT_EN)
- out_valid  out  1  result, carry_out, overflow are valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  sum/difference
- carry_out  out  1  carry out of MSB; for sub, 1 = no borrow (a ≥ b unsigned)
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch a_r=a, b_r = sub ? ~b : b, carry_r = sub;
  - clear idx to 0 and the result register to 0;
  - go to RUN.
- RUN: in_ready=0. The adder is fed a_r[4·idx+:4], b_r[4·idx+:4], carry_r each cycle.
  - The sum nibble is written to result[4·idx+:4]; carry_r takes the nibble carry out.
  - At idx=NIB−1: capture carry_out = nibble carry out, and overflow = (carry into bit 3 of the nibble) XOR (nibble carry out); go to DONE.
  - Otherwise idx increments.
- DONE: out_valid=1. Result and flags hold stable while out_ready=0. On out_ready, go to IDLE with out_valid=0.
- No new operation is accepted before the result is consumed. in_valid outside IDLE is ignored.
- idx width is clog2(NIB), minimum 1. idx never wraps past NIB−1.
- WIDTH=4 degenerates to a single RUN cycle.
- Reset:
  - rst has priority over every transition, including mid-RUN and DONE. The in-flight operation is discarded.
  - Next state after reset is IDLE.
  - Reset values: in_ready=1, out_valid=0, busy=0, result=0, carry_out=0, overflow=0.
  - Internal a_r, b_r, carry_r, idx are cleared to 0.

## Timing
- Acceptance at edge T. RUN occupies edges T+1 … T+NIB. out_valid is high from just after edge T+NIB.
- Latency is NIB cycles from acceptance to out_valid.
- The consume edge returns the FSM to IDLE. The next acceptance occurs at the earliest one edge later.
- Maximum throughput is one operation per NIB+2 cycles.
- All outputs are registered. No combinational path runs from in_valid/out_ready to any output except none; in_ready is decoded from the state register only.
- The critical path is one 4-bit ripple carry plus the nibble mux.

## Configuration
- SERIAL_ADDER_SAT_EN defined:
  - the sat port exists and is latched with the operands at acceptance.
  - If sat_r=1 and overflow=1, result is replaced in the DONE-entry cycle: WIDTH'h7FF…F when the MSB of the raw result is 1 (positive overflow), else WIDTH'h800…0.
  - overflow still reports the raw overflow; carry_out is unaffected.
- SERIAL_ADDER_SAT_EN undefined:
  - the sat port is absent, no clamp logic is built, and result is always the raw modular result.

## Structure
- Package serial_adder_pkg:
  - state enum (IDLE, RUN, DONE);
  - localparam NIBBLE_W=4;
  - the function deriving NIB and idx width from WIDTH.
- The single sub-module is the existing four_bit_adder, instantiated once as the shared datapath. Its overflow output supplies the MSB-nibble overflow.
- The controller holds the FSM, operand registers, index counter, result assembly and optional clamp.

## Test plan
WIDTH=16 unless noted; expected latency is 4 cycles.
1. add 0x1234+0x0FCD → result 0x2201, carry_out 0, overflow 0. out_valid rises exactly 4 cycles after acceptance.
2. add 0xFFFF+0x0001 → 0x0000, carry_out 1, overflow 0. add 0x7FFF+0x0001 → 0x8000, overflow 1, carry_out 0. With SERIAL_ADDER_SAT_EN and sat=1 → 0x7FFF, overflow 1.
3. sub 0x0005−0x0007 → 0xFFFE, carry_out 0, overflow 0. sub 0x8000−0x0001 → 0x7FFF, carry_out 1, overflow 1. With sat=1 → 0x8000.
4. Backpressure: out_ready=0 for 5 cycles in DONE → result and flags stable, in_ready=0, and new in_valid is ignored. out_ready=1 → IDLE next cycle, then the next op is accepted.
5. Reset mid-operation: rst=1 on the 2nd RUN cycle → next cycle IDLE, in_ready=1, out_valid=0, result=0. A following add 0x0001+0x0001 gives 0x0002.
6. WIDTH=4: add 0x7+0x1 → 0x8, overflow 1, latency 1 cycle. Random back-to-back ops are compared against a reference model for WIDTH 4/8/16/32.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared types and sizing helpers for the nibble-serial adder controller.
//   state_t    : controller FSM encoding (IDLE, RUN, DONE)
//   NIBBLE_W   : width of the shared adder slice
//   nib_count  : number of nibbles in an operand of a given width
//   idx_width  : width of the nibble index counter (at least 1 bit)
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;

   function automatic int nib_count(input int width);
      return width / NIBBLE_W;
   endfunction

   function automatic int idx_width(input int width);
      int n;
      n = width / NIBBLE_W;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_controller_four_bit_adder.sv
// four_bit_adder
// Plain 4-bit ripple-carry adder used as the shared datapath slice.
// Ports:
//   a, b      : nibble operands
//   cin       : carry in
//   sum       : nibble sum
//   cout      : carry out of bit 3
//   overflow  : carry into bit 3 XOR carry out of bit 3 (signed overflow
//               when this slice holds the operand MSB)
module four_bit_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout,
   output logic       overflow
);

   logic [4:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      end
   end

   assign cout     = c[4];
   assign overflow = c[3] ^ c[4];

endmodule

// File: rtl/serial_adder_controller.sv
// serial_adder_controller
// Sequences one shared 4-bit adder to add or subtract WIDTH-bit operands,
// one nibble per clock, least-significant nibble first.
// Optional feature macro: SERIAL_ADDER_SAT_EN (adds the sat port and the
// signed-overflow clamp applied when the result is produced).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (a, b, sub [, sat])
//   a, b                : WIDTH-bit operands
//   sub                 : 0 = a+b, 1 = a-b
//   sat                 : clamp on signed overflow (SERIAL_ADDER_SAT_EN only)
//   out_valid, out_ready: result handshake
//   result              : sum / difference
//   carry_out           : MSB carry out (for sub, 1 = no borrow)
//   overflow            : signed overflow of the raw result
//   busy                : operation in flight or awaiting consumption
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// RUN   | one nibble added per clock, idx selects the nibble
// DONE  | out_valid high, result held until out_ready
module serial_adder_controller
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
`ifdef SERIAL_ADDER_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             busy
);

   localparam int NIB   = nib_count(WIDTH);
   localparam int IDX_W = idx_width(WIDTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

   state_t               state;
   logic [WIDTH-1:0]     a_r;
   logic [WIDTH-1:0]     b_r;
   logic                 carry_r;
   logic [IDX_W-1:0]     idx;
`ifdef SERIAL_ADDER_SAT_EN
   logic                 sat_r;
`endif

   logic [NIBBLE_W-1:0]  nib_a;
   logic [NIBBLE_W-1:0]  nib_b;
   logic [NIBBLE_W-1:0]  nib_sum;
   logic                 nib_cout;
   logic                 nib_ovf;
   logic [WIDTH-1:0]     sum_placed;

   // Shift the operand down so the selected nibble lands in the low bits;
   // avoids an out-of-range part-select when WIDTH == 4.
   assign nib_a = NIBBLE_W'(a_r >> (NIBBLE_W * idx));
   assign nib_b = NIBBLE_W'(b_r >> (NIBBLE_W * idx));

   // result is cleared at acceptance, so OR-ing each placed nibble in
   // assembles result[4*idx +: 4] without a variable part-select write.
   assign sum_placed = WIDTH'(nib_sum) << (NIBBLE_W * idx);

   four_bit_adder u_adder (
      .a        (nib_a),
      .b        (nib_b),
      .cin      (carry_r),
      .sum      (nib_sum),
      .cout     (nib_cout),
      .overflow (nib_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
         carry_r   <= 1'b0;
         idx       <= '0;
`ifdef SERIAL_ADDER_SAT_EN
         sat_r     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= a;
                  // Subtraction as a + ~b + 1: the +1 enters as carry in.
                  b_r      <= sub ? ~b : b;
                  carry_r  <= sub;
                  idx      <= '0;
                  result   <= '0;
`ifdef SERIAL_ADDER_SAT_EN
                  sat_r    <= sat;
`endif
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end

            RUN: begin
               result  <= result | sum_placed;
               carry_r <= nib_cout;
               if (idx == IDX_LAST) begin
                  carry_out <= nib_cout;
                  overflow  <= nib_ovf;
                  state     <= DONE;
                  out_valid <= 1'b1;
`ifdef SERIAL_ADDER_SAT_EN
                  // Raw MSB set on overflow means the true result was positive.
                  if (sat_r && nib_ovf) begin
                     result <= nib_sum[NIBBLE_W-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                                   : {1'b1, {(WIDTH-1){1'b0}}};
                  end
`endif
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end

            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end

            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_controller.sv
module tb_serial_adder_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] a_bus;
   logic [31:0] b_bus;
   logic        sub_i;
`ifdef SERIAL_ADDER_SAT_EN
   logic        sat_i;
`endif

   // index 0..3 -> WIDTH 4, 8, 16, 32
   logic [3:0]  ir_v, ovl_v, busy_v, co_v, ovf_v;
   logic [3:0]  res4;
   logic [7:0]  res8;
   logic [15:0] res16;
   logic [31:0] res32;
   logic [31:0] res_x [4];

   assign res_x[0] = 32'(res4);
   assign res_x[1] = 32'(res8);
   assign res_x[2] = 32'(res16);
   assign res_x[3] = res32;

   int n_assert = 0;
   int n_fail   = 0;
   int lat [4];
   int wid [4] = '{4, 8, 16, 32};

   always #5 clk = ~clk;

   serial_adder_controller #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_v[0]),
      .a(a_bus[3:0]), .b(b_bus[3:0]), .sub(sub_i),
`ifdef SERIAL_ADDER_SAT_EN
      .sat(sat_i),
`endif
      .out_valid(ovl_v[0]), .out_ready(out_ready), .result(res4),
      .carry_out(co_v[0]), .overflow(ovf_v[0]), .busy(busy_v[0]));

   serial_adder_controller #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_v[1]),
      .a(a_bus[7:0]), .b(b_bus[7:0]), .sub(sub_i),
`ifdef SERIAL_ADDER_SAT_EN
      .sat(sat_i),
`endif
      .out_valid(ovl_v[1]), .out_ready(out_ready), .result(res8),
      .carry_out(co_v[1]), .overflow(ovf_v[1]), .busy(busy_v[1]));

   serial_adder_controller #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_v[2]),
      .a(a_bus[15:0]), .b(b_bus[15:0]), .sub(sub_i),
`ifdef SERIAL_ADDER_SAT_EN
      .sat(sat_i),
`endif
      .out_valid(ovl_v[2]), .out_ready(out_ready), .result(res16),
      .carry_out(co_v[2]), .overflow(ovf_v[2]), .busy(busy_v[2]));

   serial_adder_controller #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_v[3]),
      .a(a_bus), .b(b_bus), .sub(sub_i),
`ifdef SERIAL_ADDER_SAT_EN
      .sat(sat_i),
`endif
      .out_valid(ovl_v[3]), .out_ready(out_ready), .result(res32),
      .carry_out(co_v[3]), .overflow(ovf_v[3]), .busy(busy_v[3]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one operation into all DUTs, then wait (bounded) for every out_valid.
   // Returns #1 after the edge on which the slowest DUT raised out_valid.
   task automatic op(input logic [31:0] av, input logic [31:0] bv, input logic sv);
      a_bus    = av;
      b_bus    = bv;
      sub_i    = sv;
      in_valid = 1'b1;
      check("accept_in_ready", 32'(ir_v), 32'hF);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("run_busy", 32'(busy_v), 32'hF);
      check("run_in_ready", 32'(ir_v), 32'h0);
      for (int i = 0; i < 4; i++) lat[i] = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++)
            if (ovl_v[i] && lat[i] == 0) lat[i] = c;
         if (&ovl_v) break;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("consume_out_valid", 32'(ovl_v), 32'h0);
      check("consume_in_ready", 32'(ir_v), 32'hF);
      check("consume_busy", 32'(busy_v), 32'h0);
   endtask

   // Independent arithmetic reference: widened add, sign-rule overflow.
   task automatic model(input int w, input logic [31:0] av, input logic [31:0] bv, input logic sv,
                        output logic [31:0] r, output logic c, output logic o);
      logic [32:0] m, aa, bb, bo, s;
      m  = (33'd1 << w) - 33'd1;
      aa = {1'b0, av} & m;
      bo = {1'b0, bv} & m;
      bb = {1'b0, (sv ? ~bv : bv)} & m;
      s  = aa + bb + 33'(sv);
      c  = s[w];
      r  = s[31:0] & m[31:0];
      if (sv) o = (aa[w-1] != bo[w-1]) && (r[w-1] != aa[w-1]);
      else    o = (aa[w-1] == bo[w-1]) && (r[w-1] != aa[w-1]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] mr, av, bv;
      logic        mc, mo, sv;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a_bus = '0; b_bus = '0; sub_i = 1'b0;
`ifdef SERIAL_ADDER_SAT_EN
      sat_i = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready", 32'(ir_v), 32'hF);
      check("rst_out_valid", 32'(ovl_v), 32'h0);
      check("rst_busy", 32'(busy_v), 32'h0);
      check("rst_result16", 32'(res16), 32'h0);
      check("rst_carry", 32'(co_v), 32'h0);
      check("rst_overflow", 32'(ovf_v), 32'h0);

      // 1: basic add, latency 4 for WIDTH=16
      op(32'h1234, 32'h0FCD, 1'b0);
      check("t1_result", 32'(res16), 32'h2201);
      check("t1_carry", 32'(co_v[2]), 32'd0);
      check("t1_ovf", 32'(ovf_v[2]), 32'd0);
      check("t1_latency", 32'(lat[2]), 32'd4);
      consume();

      // 2: unsigned wrap and signed overflow
      op(32'hFFFF, 32'h0001, 1'b0);
      check("t2a_result", 32'(res16), 32'h0000);
      check("t2a_carry", 32'(co_v[2]), 32'd1);
      check("t2a_ovf", 32'(ovf_v[2]), 32'd0);
      consume();
      op(32'h7FFF, 32'h0001, 1'b0);
      check("t2b_result", 32'(res16), 32'h8000);
      check("t2b_carry", 32'(co_v[2]), 32'd0);
      check("t2b_ovf", 32'(ovf_v[2]), 32'd1);
      consume();

      // 3: subtraction with borrow and signed overflow
      op(32'h0005, 32'h0007, 1'b1);
      check("t3a_result", 32'(res16), 32'hFFFE);
      check("t3a_carry", 32'(co_v[2]), 32'd0);
      check("t3a_ovf", 32'(ovf_v[2]), 32'd0);
      consume();
      op(32'h8000, 32'h0001, 1'b1);
      check("t3b_result", 32'(res16), 32'h7FFF);
      check("t3b_carry", 32'(co_v[2]), 32'd1);
      check("t3b_ovf", 32'(ovf_v[2]), 32'd1);
      consume();

`ifdef SERIAL_ADDER_SAT_EN
      sat_i = 1'b1;
      op(32'h7FFF, 32'h0001, 1'b0);
      check("sat_pos_result", 32'(res16), 32'h7FFF);
      check("sat_pos_ovf", 32'(ovf_v[2]), 32'd1);
      consume();
      op(32'h8000, 32'h0001, 1'b1);
      check("sat_neg_result", 32'(res16), 32'h8000);
      check("sat_neg_ovf", 32'(ovf_v[2]), 32'd1);
      check("sat_neg_carry", 32'(co_v[2]), 32'd1);
      consume();
      op(32'h1234, 32'h0FCD, 1'b0);
      check("sat_noovf_result", 32'(res16), 32'h2201);
      consume();
      sat_i = 1'b0;
`endif

      // 4: backpressure, new in_valid ignored while DONE
      op(32'h0003, 32'h0004, 1'b0);
      a_bus = 32'h1111; b_bus = 32'h2222; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check("bp_result", 32'(res16), 32'h0007);
         check("bp_out_valid", 32'(ovl_v[2]), 32'd1);
         check("bp_in_ready", 32'(ir_v[2]), 32'd0);
      end
      in_valid = 1'b0;
      consume();
      op(32'h0100, 32'h0023, 1'b0);
      check("bp_next_result", 32'(res16), 32'h0123);
      check("bp_next_latency", 32'(lat[2]), 32'd4);
      consume();

      // 5: reset on the second RUN cycle
      a_bus = 32'h1111; b_bus = 32'h1111; sub_i = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_partial", 32'(res16), 32'h0002);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_mid_in_ready", 32'(ir_v[2]), 32'd1);
      check("rst_mid_out_valid", 32'(ovl_v[2]), 32'd0);
      check("rst_mid_result", 32'(res16), 32'h0);
      check("rst_mid_busy", 32'(busy_v[2]), 32'd0);
      op(32'h0001, 32'h0001, 1'b0);
      check("rst_after_result", 32'(res16), 32'h0002);
      check("rst_after_latency", 32'(lat[2]), 32'd4);
      consume();

      // 6: WIDTH=4 single-cycle run
      op(32'h7, 32'h1, 1'b0);
      check("w4_result", 32'(res4), 32'h8);
      check("w4_ovf", 32'(ovf_v[0]), 32'd1);
      check("w4_carry", 32'(co_v[0]), 32'd0);
      check("w4_latency", 32'(lat[0]), 32'd1);
      check("w8_latency", 32'(lat[1]), 32'd2);
      check("w32_latency", 32'(lat[3]), 32'd8);
      consume();

      // Random back-to-back operations against the reference for all widths
      for (int n = 0; n < 24; n++) begin
         av = $urandom;
         bv = $urandom;
         sv = 1'($urandom_range(0, 1));
         op(av, bv, sv);
         for (int i = 0; i < 4; i++) begin
            model(wid[i], av, bv, sv, mr, mc, mo);
            check($sformatf("rnd%0d_w%0d_result", n, wid[i]), res_x[i], mr);
            check($sformatf("rnd%0d_w%0d_carry", n, wid[i]), 32'(co_v[i]), 32'(mc));
            check($sformatf("rnd%0d_w%0d_ovf", n, wid[i]), 32'(ovf_v[i]), 32'(mo));
            check($sformatf("rnd%0d_w%0d_latency", n, wid[i]), 32'(lat[i]), 32'(wid[i] / 4));
         end
         consume();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
